alu_uart_interface: RTL and testbench

ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

---
 rtl/alu_uart_interface_pkg.sv | 32 +++
 rtl/alu_uart_interface.sv | 94 +++++++++
 tb/tb_alu_uart_interface.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the ALU/UART byte-protocol slice.
//   - ALU opcode constants (6-bit, MIPS-style function codes)
//   - FSM state encoding for alu_uart_interface
//   - helper that classifies which states refuse incoming rx bytes
package alu_uart_interface_pkg;

  localparam int ALU_NB_OP = 6;

  localparam logic [ALU_NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [ALU_NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [ALU_NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [ALU_NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [ALU_NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [ALU_NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [ALU_NB_OP-1:0] OP_SRL = 6'b000010;
  localparam logic [ALU_NB_OP-1:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    ST_OP1     = 3'd0,
    ST_OP2     = 3'd1,
    ST_OPC     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT    = 3'd5
  } state_t;

  // States in which a result is in flight and rx bytes are discarded.
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_CAPTURE) || (s == ST_SEND) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/alu_uart_interface.sv
// alu_uart_interface: collects operand1, operand2 and opcode bytes from a
// UART receiver, presents them registered to an external combinational ALU,
// captures the ALU result and hands it to a UART transmitter.
//
// Ports
//   i_clk        : clock, all logic on the rising edge
//   i_reset      : synchronous active-high reset
//   i_rx_data    : received byte          i_rx_valid : one-cycle qualifier
//   o_operand1   : registered operand 1   o_operand2 : registered operand 2
//   o_opcode     : registered opcode (low NB_OP bits of the third byte)
//   i_alu_result : combinational ALU result
//   o_tx_data    : captured result byte   o_tx_start : one-cycle launch pulse
//   i_tx_busy    : transmitter occupied   i_tx_done  : end-of-transmission pulse
//   o_busy       : high while a result is being captured/sent
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_operand1,
  output logic [NB_DATA-1:0] o_operand2,
  output logic [NB_OP-1:0]   o_opcode,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic               o_busy
);

  state_t state_q;
  state_t state_d;

  logic ld_op1;
  logic ld_op2;
  logic ld_opc;
  logic ld_res;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_OP1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OP1:     if (i_rx_valid) state_d = ST_OP2;
      ST_OP2:     if (i_rx_valid) state_d = ST_OPC;
      ST_OPC:     if (i_rx_valid) state_d = ST_CAPTURE;
      // The ALU has had one full cycle on the registered operands here.
      ST_CAPTURE: state_d = ST_SEND;
      ST_SEND:    if (!i_tx_busy) state_d = ST_WAIT;
      ST_WAIT:    if (i_tx_done) state_d = ST_OP1;
      default:    state_d = ST_OP1;
    endcase
  end

  // Output / load-enable decode
  always_comb begin
    ld_op1     = (state_q == ST_OP1) && i_rx_valid;
    ld_op2     = (state_q == ST_OP2) && i_rx_valid;
    ld_opc     = (state_q == ST_OPC) && i_rx_valid;
    ld_res     = (state_q == ST_CAPTURE);
    // Mealy so the launch lands in the same cycle the transmitter frees up.
    o_tx_start = (state_q == ST_SEND) && !i_tx_busy;
    o_busy     = is_busy_state(state_q);
  end

  // Operand, opcode and result registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_operand1 <= '0;
      o_operand2 <= '0;
      o_opcode   <= '0;
      o_tx_data  <= '0;
    end else begin
      if (ld_op1) o_operand1 <= i_rx_data;
      if (ld_op2) o_operand2 <= i_rx_data;
      if (ld_opc) o_opcode   <= i_rx_data[NB_OP-1:0];
      if (ld_res) o_tx_data  <= i_alu_result;
    end
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] op1;
  logic [7:0] op2;
  logic [5:0] opc;
  logic [7:0] alu_res;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       busy;
  logic signed [7:0] s_op1;

  int chk = 0;
  int err = 0;

  always #5 clk = ~clk;

  alu_uart_interface #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_operand1(op1), .o_operand2(op2), .o_opcode(opc),
    .i_alu_result(alu_res), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_tx_busy(tx_busy), .i_tx_done(tx_done), .o_busy(busy)
  );

  // Stand-in for the ALU that sits beside the block at top level.
  assign s_op1 = op1;
  always_comb begin
    case (opc)
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SRA:  alu_res = s_op1 >>> op2;
      OP_SRL:  alu_res = op1 >> op2;
      OP_NOR:  alu_res = ~(op1 | op2);
      default: alu_res = 8'h00;
    endcase
  end

  // Reference: what the byte triple should produce, in plain integer math.
  function automatic logic [7:0] ref_result(input int a, input int b, input int code);
    int r;
    int sa;
    sa = (a >= 128) ? a - 256 : a;
    case (code)
      32: r = a + b;
      34: r = a - b;
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      3:  r = (b >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> b);
      2:  r = (b >= 8) ? 0 : (a >> b);
      39: r = ~(a | b);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  // Sends a triple, plays the transmitter, finishes with a tx_done pulse.
  // junk=1 keeps rx_valid and tx_done asserted while they must be ignored.
  task automatic run_triple(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input int busy_cycles, input bit junk,
                            output int lat, output logic [7:0] data,
                            output int pulses, output bit busy_hi);
    lat = -1; data = 8'h00; pulses = 0; busy_hi = 1'b1;
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    for (int c = 1; c <= busy_cycles + 6; c++) begin
      if (c > 1) step();
      tx_busy = (c >= 2) && (c < 2 + busy_cycles);
      tx_done = junk && (c < 2 + busy_cycles);
      if (junk) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom_range(0, 255));
      end
      #1;
      if (busy !== 1'b1) busy_hi = 1'b0;
      if (tx_start === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat  = c;
          data = tx_data;
        end
      end
    end
    tx_busy = 1'b0;
    tx_done = 1'b1;
    step();
    tx_done  = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5; tx_done = 1'b1; tx_busy = 1'b0;
    step(); step();
    rst = 1'b0; rx_valid = 1'b0; tx_done = 1'b0;
    #1;
    chk++; if (op1 !== 8'h00) begin err++; $display("FAIL reset_op1 got %h exp 00", op1); end
    chk++; if (op2 !== 8'h00) begin err++; $display("FAIL reset_op2 got %h exp 00", op2); end
    chk++; if (opc !== 6'h00) begin err++; $display("FAIL reset_opc got %h exp 00", opc); end
    chk++; if (tx_data !== 8'h00) begin err++; $display("FAIL reset_txdata got %h exp 00", tx_data); end
    chk++; if (tx_start !== 1'b0) begin err++; $display("FAIL reset_txstart got %b exp 0", tx_start); end
    chk++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_add();
    int lat, pulses; logic [7:0] d; bit bh;
    run_triple(8'h05, 8'h03, 8'h20, 0, 1'b0, lat, d, pulses, bh);
    chk++; if (d !== 8'h08) begin err++; $display("FAIL add_data got %h exp 08", d); end
    chk++; if (lat !== 2) begin err++; $display("FAIL add_latency got %0d exp 2", lat); end
    chk++; if (pulses !== 1) begin err++; $display("FAIL add_pulses got %0d exp 1", pulses); end
    chk++; if (bh !== 1'b1) begin err++; $display("FAIL add_busy_during got %b exp 1", bh); end
    chk++; if (busy !== 1'b0) begin err++; $display("FAIL add_busy_after got %b exp 0", busy); end
    chk++; if (tx_data !== 8'h08) begin err++; $display("FAIL add_hold got %h exp 08", tx_data); end
    chk++; if (op1 !== 8'h05 || op2 !== 8'h03) begin err++; $display("FAIL add_operands got %h %h exp 05 03", op1, op2); end
    chk++; if (opc !== 6'h20) begin err++; $display("FAIL add_opcode got %h exp 20", opc); end
  endtask

  task automatic test_ops();
    logic [7:0] tb1 [5] = '{8'h03, 8'h80, 8'h80, 8'h05, 8'h07};
    logic [7:0] tb2 [5] = '{8'h05, 8'h02, 8'h02, 8'h3C, 8'h0E};
    logic [7:0] tb3 [5] = '{8'h22, 8'h03, 8'h02, 8'h3F, 8'hE0};
    logic [7:0] exp [5] = '{8'hFE, 8'hE0, 8'h20, 8'h00, 8'h15};
    int lat, pulses; logic [7:0] d; bit bh;
    for (int i = 0; i < 5; i++) begin
      run_triple(tb1[i], tb2[i], tb3[i], 0, 1'b0, lat, d, pulses, bh);
      chk++; if (d !== exp[i]) begin err++; $display("FAIL ops_data[%0d] got %h exp %h", i, d, exp[i]); end
      chk++; if (lat !== 2 || pulses !== 1) begin err++; $display("FAIL ops_timing[%0d] got lat %0d pulses %0d exp 2 1", i, lat, pulses); end
    end
    chk++; if (opc !== 6'h20) begin err++; $display("FAIL opcode_mask got %h exp 20", opc); end
  endtask

  task automatic test_tx_busy();
    int lat, pulses; logic [7:0] d; bit bh;
    run_triple(8'h10, 8'h22, 8'h25, 10, 1'b0, lat, d, pulses, bh);
    chk++; if (lat !== 12) begin err++; $display("FAIL busy_latency got %0d exp 12", lat); end
    chk++; if (pulses !== 1) begin err++; $display("FAIL busy_pulses got %0d exp 1", pulses); end
    chk++; if (d !== 8'h32) begin err++; $display("FAIL busy_data got %h exp 32", d); end
    chk++; if (bh !== 1'b1) begin err++; $display("FAIL busy_flag got %b exp 1", bh); end
  endtask

  task automatic test_drop();
    int lat, pulses; logic [7:0] d; bit bh;
    run_triple(8'hC3, 8'h0F, 8'h26, 3, 1'b1, lat, d, pulses, bh);
    chk++; if (op1 !== 8'hC3 || op2 !== 8'h0F) begin err++; $display("FAIL drop_operands got %h %h exp c3 0f", op1, op2); end
    chk++; if (opc !== 6'h26) begin err++; $display("FAIL drop_opcode got %h exp 26", opc); end
    chk++; if (d !== 8'hCC || lat !== 5 || pulses !== 1) begin err++; $display("FAIL drop_result got %h lat %0d pulses %0d exp cc 5 1", d, lat, pulses); end
    chk++; if (tx_data !== 8'hCC) begin err++; $display("FAIL drop_hold got %h exp cc", tx_data); end
    run_triple(8'h09, 8'h06, 8'h24, 0, 1'b0, lat, d, pulses, bh);
    chk++; if (d !== 8'h00 || lat !== 2) begin err++; $display("FAIL drop_next got %h lat %0d exp 00 2", d, lat); end
  endtask

  task automatic test_reset_mid();
    int lat, pulses; logic [7:0] d; bit bh;
    send_byte(8'hAA);
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    step();
    rst = 1'b0; rx_valid = 1'b0;
    #1;
    chk++; if (op1 !== 8'h00 || op2 !== 8'h00 || opc !== 6'h00) begin err++; $display("FAIL rstmid_regs got %h %h %h exp 0 0 0", op1, op2, opc); end
    chk++; if (tx_data !== 8'h00 || tx_start !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL rstmid_out got %h %b %b exp 00 0 0", tx_data, tx_start, busy); end
    run_triple(8'h05, 8'h03, 8'h20, 0, 1'b0, lat, d, pulses, bh);
    chk++; if (d !== 8'h08 || lat !== 2 || pulses !== 1) begin err++; $display("FAIL rstmid_fresh got %h lat %0d pulses %0d exp 08 2 1", d, lat, pulses); end
    // Reset in ST_WAIT together with tx_done.
    send_byte(8'h40); send_byte(8'h01); send_byte(8'h21);
    step(); step();
    chk++; if (busy !== 1'b1) begin err++; $display("FAIL rstwait_pre got %b exp 1", busy); end
    rst = 1'b1; tx_done = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    step();
    rst = 1'b0; tx_done = 1'b0; rx_valid = 1'b0;
    #1;
    chk++; if (busy !== 1'b0 || tx_data !== 8'h00 || op1 !== 8'h00) begin err++; $display("FAIL rstwait_out got busy %b data %h op1 %h exp 0 00 00", busy, tx_data, op1); end
    send_byte(8'h11);
    chk++; if (op1 !== 8'h11 || op2 !== 8'h00) begin err++; $display("FAIL rstwait_op1 got %h %h exp 11 00", op1, op2); end
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] codes [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    int lat, pulses; logic [7:0] d; bit bh;
    logic [7:0] a, b, c, e;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 4 == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
      c = {2'($urandom_range(0, 3)), (i % 5 == 4) ? 6'($urandom_range(0, 63)) : codes[i % 8]};
      e = ref_result(int'(a), int'(b), int'(c[5:0]));
      run_triple(a, b, c, i % 3, i[0], lat, d, pulses, bh);
      chk++; if (d !== e) begin err++; $display("FAIL rand_data[%0d] %h %h %h got %h exp %h", i, a, b, c, d, e); end
      chk++; if (lat !== 2 + (i % 3) || pulses !== 1) begin err++; $display("FAIL rand_timing[%0d] got lat %0d pulses %0d exp %0d 1", i, lat, pulses, 2 + (i % 3)); end
      chk++; if (opc !== c[5:0] || busy !== 1'b0) begin err++; $display("FAIL rand_state[%0d] got opc %h busy %b exp %h 0", i, opc, busy, c[5:0]); end
    end
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
    test_reset();
    test_add();
    test_ops();
    test_tx_busy();
    test_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after 2ms simulated");
    $fatal(1, "watchdog");
  end

endmodule
